// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and defaults for the multi-port register file.
// State encoding, default widths and the read-port limit.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int MAX_NRD    = 8;

endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: CLEAR/RUN sequencer that zeroes every entry after reset.
// Ports: clk, reset_n (sync, active-low) -> clr_we, clr_addr, run, ready, clr_busy.
module rf_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              run,
  output logic              ready,
  output logic              clr_busy
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Pointer stops on the last entry rather than wrapping.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_ptr_q == LAST) state_d = RUN;
        else clr_ptr_d = clr_ptr_q + 1'b1;
      end
      RUN: ;
      default: state_d = CLEAR;
    endcase
  end

  // The reset edge itself must not write the array.
  always_comb begin
    clr_we   = reset_n && (state_q == CLEAR);
    clr_addr = clr_ptr_q;
    run      = (state_q == RUN);
    ready    = (state_q == RUN);
    clr_busy = (state_q == CLEAR);
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD combinational read ports, one clocked write port, self-clear.
// Ports: clk, reset_n, we/wa/wd, ra/rd (packed per port), ready, clr_busy.
// Build option: REGFILE_BYPASS_EN forwards wd to matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wa,
  input  logic [DATA_W-1:0]     wd,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic                  ready,
  output logic                  clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  if (NRD < 1 || NRD > MAX_NRD) begin : g_bad_nrd
    $error("regfile_mp: NRD must be within 1..8");
  end

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              run;
  logic              ext_we;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] mem_q [DEPTH];

  rf_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clr (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .run     (run),
    .ready   (ready),
    .clr_busy(clr_busy)
  );

  always_comb begin
    ext_we = run && we && !((ZERO_REG != 0) && (wa == '0));
  end

  // Clear path owns the write port whenever the sequencer is active.
  always_comb begin
    wr_en   = reset_n && (clr_we || ext_we);
    wr_addr = clr_we ? clr_addr : wa;
    wr_data = clr_we ? '0 : wd;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_i;
    logic [DATA_W-1:0] rd_i;

    assign ra_i = ra[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd_i = mem_q[ra_i];
`ifdef REGFILE_BYPASS_EN
      if (ext_we && (wa == ra_i)) rd_i = wd;
`endif
      // Hide stale contents until the clear finishes.
      if (!run || ((ZERO_REG != 0) && (ra_i == '0))) rd_i = '0;
    end

    assign rd[i*DATA_W +: DATA_W] = rd_i;
  end

endmodule
